jtdd2_sdram_arb: RTL and testbench
==================================

// Module: jtdd2_sdram_arb
// PURPOSE
// Four-requester SDRAM read arbiter for the JTDD2 game top. It shares the single
// SDRAM read port between CPU/sound ROM fetchers and the graphics fetchers.
// Each slot has a one-entry 32-bit cache tagged by word address. The arbiter
// gates graphics slots during vertical blank and releases the bus for refresh when idle.
// PARAMETERS
// AW         22       SDRAM word-address width
// PRIO_SLOT  0        slot index with fixed priority over round-robin
// GATE_MASK  4'b1100  slots that are not served while vblank=1
// TIMEOUT    63       max cycles in REQ+WAIT before abort; 6-bit counter
// PORTS
// clk          in   1       system clock (48 MHz)
// rst          in   1       reset, synchronous, active-high
// vblank       in   1       vertical blank; gates slots in GATE_MASK
// downloading  in   1       ROM download in progress; arbiter idle
// slot_cs      in   4       per-slot read request
// slot_addr    in   4*AW    per-slot word address, already offset; slot i = [i*AW+:AW]
// slot_ok      out  4       slot_dout valid for the current slot_addr
// slot_dout    out  4*32    per-slot cached data; slot i = [i*32+:32]
// sdram_req    out  1       read request to SDRAM controller
// sdram_ack    in   1       controller accepted request
// data_rdy     in   1       data_read valid (single-cycle strobe)
// data_read    in   32      SDRAM read data
// sdram_addr   out  AW      address of the current request
// refresh_en   out  1       controller may refresh
// BEHAVIOUR
// - Reset: sdram_req=0, sdram_addr=0, slot_dout=0, all valid bits=0, slot_ok=0,
//   refresh_en=1, state=IDLE, rr_last=3 (first round-robin scan starts at slot 0).
// - hit[i] = valid[i] && tag[i]==slot_addr[i]. slot_ok[i] = slot_cs[i] && hit[i]
//   (combinational from registers). When cs is low, slot_ok is 0 and the cache is kept.
// - pend[i] = slot_cs[i] && !hit[i] && !(GATE_MASK[i] && vblank).
// - FSM: IDLE -> REQ -> WAIT -> IDLE.
//   IDLE: if downloading, stay. Else, if pend[PRIO_SLOT], win=PRIO_SLOT.
//     Else the first pending slot scanning rr_last+1, +2, ... modulo 4.
//     On a winner: sdram_addr<=slot_addr[win], valid[win]<=0, sdram_req<=1,
//     timer<=0, go to REQ.
//   REQ: hold sdram_req=1 and a stable sdram_addr. On sdram_ack: sdram_req<=0,
//     go to WAIT.
//   WAIT: on data_rdy: slot_dout[win]<=data_read, tag[win]<=sdram_addr,
//     valid[win]<=1, rr_last<=win, go to IDLE.
//     slot_ok rises the cycle after data_rdy (latency 1).
// - The PRIO_SLOT win does not update rr_last, so round-robin fairness is kept.
// - Requester changes address mid-fill: the fill completes with the old tag.
//   slot_ok stays 0 because the tag mismatches. A new request issues from the next IDLE.
// - vblank rises mid-fill: the fill completes. Gating applies only in IDLE.
// - sdram_ack and data_rdy in the same cycle in REQ: treat as ack+data. Fill and
//   go to IDLE directly.
// - Timeout: timer increments in REQ and WAIT. When timer==TIMEOUT: sdram_req<=0,
//   go to IDLE. No cache update; valid[win] stays 0, so the slot re-requests.
// - downloading=1 in any state: sdram_req<=0, clear all valid bits next cycle,
//   go to IDLE. Stay idle while it is high.
// - refresh_en = (state==IDLE) && (pend==0). It is also 1 during downloading.
// - sdram_addr holds its last value when idle.
// TESTING
// 1 Reset, then cs=4'b0001, addr0=0x10000, ack at +2, data_rdy=0xA5A5_1234 at +5
//   -> req pulses; slot_ok[0]=1 one cycle after data_rdy; dout0=0xA5A51234.
// 2 Slots 1,2,3 pending with PRIO_SLOT=0 idle -> service order 1,2,3. Then slot 0 and
//   slot 1 miss together -> slot 0 served first, then slot 1.
// 3 vblank=1, slots 2 and 3 pending with new addresses -> no sdram_req; refresh_en=1.
//   vblank=0 -> slot 2 served, then slot 3.
// 4 Slot 1 fill for 0x200. Change addr1 to 0x204 before data_rdy -> slot_ok[1] stays 0.
//   A second request for 0x204 follows; slot_ok[1]=1 after it.
// 5 ack never arrives -> sdram_req drops 63 cycles after REQ entry; FSM in IDLE;
//   the request for the same slot reissues.
// 6 downloading=1 mid-WAIT -> sdram_req=0 and all slot_ok=0 next cycle.
//   After release, a previously hit address misses and re-fetches.

Source files
------------

// File: rtl/jtdd2_sdram_arb_if.sv
// jtdd2_sdram_arb_if
// Bundles the requester side and the SDRAM controller side of the JTDD2
// read arbiter.
//   slave  : the arbiter itself (receives requests, drives the SDRAM read request)
//   master : everything around it (requesters plus SDRAM controller)
// Signals:
//   slot_cs[4], slot_addr[4*AW]      per-slot read request and word address
//   slot_ok[4], slot_dout[4*32]      per-slot hit flag and cached data
//   sdram_req, sdram_addr[AW]        request to the SDRAM controller
//   sdram_ack, data_rdy, data_read   controller accept, data strobe and data
//   refresh_en                       controller may refresh
interface jtdd2_sdram_arb_if #(
    parameter int AW = 22
);
    logic [3:0]      slot_cs;
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_ok;
    logic [127:0]    slot_dout;
    logic            sdram_req;
    logic            sdram_ack;
    logic            data_rdy;
    logic [31:0]     data_read;
    logic [AW-1:0]   sdram_addr;
    logic            refresh_en;

    modport slave (
        input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        output slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );

    modport master (
        output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
        input  slot_ok, slot_dout, sdram_req, sdram_addr, refresh_en
    );
endinterface

// File: rtl/jtdd2_sdram_arb.sv
// jtdd2_sdram_arb
// Four-requester SDRAM read arbiter. Each slot keeps a one-entry 32-bit cache
// tagged by word address; a miss raises a request that is served either by
// fixed priority (PRIO_SLOT) or by round-robin. Slots in GATE_MASK are not
// started during vertical blank, and the controller is allowed to refresh
// whenever the arbiter is idle with nothing pending or a download is running.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   vblank        vertical blank, gates GATE_MASK slots
//   downloading   ROM download in progress, flushes caches and idles the arbiter
//   bus           jtdd2_sdram_arb_if.slave (requester and SDRAM controller signals)
module jtdd2_sdram_arb #(
    parameter int         AW        = 22,
    parameter int         PRIO_SLOT = 0,
    parameter logic [3:0] GATE_MASK = 4'b1100,
    parameter int         TIMEOUT   = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblank,
    input  logic             downloading,
    jtdd2_sdram_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        state, state_next;
    logic [1:0]    win, win_next, rr_last, scan;
    logic          found, issue, fill, expired;
    logic [5:0]    timer, timer_inc;
    logic [3:0]    valid, hit, pend;
    logic [AW-1:0] tag  [4];
    logic [31:0]   dout [4];
    logic          req_r;
    logic [AW-1:0] addr_r;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i]  = valid[i] && (tag[i] == bus.slot_addr[i*AW +: AW]);
            pend[i] = bus.slot_cs[i] && !hit[i] && !(GATE_MASK[i] && vblank);
        end
    end

    // The priority slot wins outright; otherwise scan starting just after the
    // last round-robin winner so every slot gets its turn.
    always_comb begin
        win_next = win;
        found    = 1'b0;
        scan     = 2'd0;
        if (pend[PRIO_SLOT]) begin
            win_next = 2'(PRIO_SLOT);
            found    = 1'b1;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                scan = rr_last + 2'(k);
                if (!found && pend[scan]) begin
                    win_next = scan;
                    found    = 1'b1;
                end
            end
        end
    end

    // The timer holds the cycles already spent on the request; the abort fires
    // on the edge where that count reaches TIMEOUT, so the bus is held for
    // at most TIMEOUT cycles.
    assign timer_inc = timer + 6'd1;
    assign expired   = (timer_inc == 6'(TIMEOUT));

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        fill       = 1'b0;
        if (downloading) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        issue      = 1'b1;
                        state_next = REQ;
                    end
                end
                REQ: begin
                    if (bus.sdram_ack) begin
                        // data arriving together with the ack completes the fill at once
                        fill       = bus.data_rdy;
                        state_next = bus.data_rdy ? IDLE : WAIT;
                    end else if (expired) begin
                        state_next = IDLE;
                    end
                end
                WAIT: begin
                    if (bus.data_rdy) begin
                        fill       = 1'b1;
                        state_next = IDLE;
                    end else if (expired) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The winner's valid bit drops at issue, so an aborted request leaves the
    // slot missing and it asks again. Priority-slot fills leave rr_last alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r   <= 1'b0;
            addr_r  <= '0;
            valid   <= '0;
            win     <= 2'd0;
            rr_last <= 2'd3;
            timer   <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                dout[i] <= '0;
            end
        end else begin
            req_r <= (state_next == REQ);
            if (issue)              timer <= '0;
            else if (state != IDLE) timer <= timer_inc;
            if (downloading) begin
                valid <= '0;
            end else if (issue) begin
                addr_r          <= bus.slot_addr[int'(win_next)*AW +: AW];
                valid[win_next] <= 1'b0;
                win             <= win_next;
            end else if (fill) begin
                dout[win]  <= bus.data_read;
                tag[win]   <= addr_r;
                valid[win] <= 1'b1;
                if (win != 2'(PRIO_SLOT)) rr_last <= win;
            end
        end
    end

    assign bus.slot_ok    = bus.slot_cs & hit;
    assign bus.sdram_req  = req_r;
    assign bus.sdram_addr = addr_r;
    assign bus.refresh_en = downloading || ((state == IDLE) && (pend == 4'd0));

    for (genvar g = 0; g < 4; g++) begin : g_dout
        assign bus.slot_dout[g*32 +: 32] = dout[g];
    end
endmodule

// File: tb/tb_jtdd2_sdram_arb.sv
// tb_jtdd2_sdram_arb
// Drives jtdd2_sdram_arb as both requesters and SDRAM controller and compares
// every output each cycle against a transaction-level reference model
// (per-slot cache arrays, a busy phase with an age count, and a winner picked
// by priority then modulo-4 round-robin). Directed scenarios come first, then
// a randomized run.
module tb_jtdd2_sdram_arb;
    localparam int         AW   = 22;
    localparam logic [3:0] GATE = 4'b1100;
    localparam int         TMO  = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic          vblank;
    logic          downloading;
    logic [3:0]    cs;
    logic [AW-1:0] addr [4];

    jtdd2_sdram_arb_if #(.AW(AW)) bus ();

    assign bus.slot_cs   = cs;
    assign bus.slot_addr = {addr[3], addr[2], addr[1], addr[0]};

    jtdd2_sdram_arb #(
        .AW(AW), .PRIO_SLOT(0), .GATE_MASK(GATE), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .downloading(downloading),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycles   = 0;
    int last_rdy = -1;

    // reference model: 0 idle, 1 request outstanding, 2 waiting for data
    int            m_phase;
    int            m_age;
    int            m_win;
    int            m_rr;
    logic [AW-1:0] m_addr;
    logic          m_valid [4];
    logic [AW-1:0] m_tag   [4];
    logic [31:0]   m_data  [4];

    // controller behaviour for the transaction in flight
    int          c_ack_dly, c_rdy_dly;
    bit          c_noack;
    logic [31:0] c_data;
    int          o_ack = -1, o_rdy = -1;
    bit          o_data_en = 0;
    logic [31:0] o_data;
    bit          force_noack = 0, random_noack = 0;

    logic [AW-1:0] obs [$];
    bit            prev_req = 0;

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cycles);
        end
    endtask

    function automatic logic [3:0] model_pend();
        logic [3:0] p;
        for (int i = 0; i < 4; i++)
            p[i] = cs[i] && !(m_valid[i] && m_tag[i] == addr[i]) && !(GATE[i] && vblank);
        return p;
    endfunction

    function automatic int model_pick(input logic [3:0] p);
        if (p[0]) return 0;
        for (int k = 1; k <= 4; k++)
            if (p[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return 0;
    endfunction

    task automatic model_fill();
        m_data[m_win]  = c_data;
        m_tag[m_win]   = m_addr;
        m_valid[m_win] = 1'b1;
        if (m_win != 0) m_rr = m_win;
        m_phase = 0;
    endtask

    // What the arbiter should do at the coming clock edge
    task automatic model_advance(input bit ack, input bit rdy);
        logic [3:0] p;
        if (downloading) begin
            m_phase = 0;
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        end else if (m_phase == 0) begin
            p = model_pend();
            if (p != 4'd0) begin
                m_win          = model_pick(p);
                m_addr         = addr[m_win];
                m_valid[m_win] = 1'b0;
                m_age          = 0;
                m_phase        = 1;
                c_noack   = force_noack || (random_noack && $urandom_range(0, 15) == 0);
                c_ack_dly = (o_ack >= 0) ? o_ack : int'($urandom_range(0, 4));
                c_rdy_dly = (o_rdy >= 0) ? o_rdy : int'($urandom_range(0, 5));
                c_data    = o_data_en ? o_data : $urandom();
            end
        end else begin
            m_age++;
            if (m_phase == 1 && ack) begin
                if (rdy) model_fill();
                else     m_phase = 2;
            end else if (m_phase == 2 && rdy) begin
                model_fill();
            end else if (m_age == TMO) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (c_ack_dly > 0) c_ack_dly--;
            end else begin
                if (c_rdy_dly > 0) c_rdy_dly--;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_ok;
        for (int i = 0; i < 4; i++)
            exp_ok[i] = cs[i] && m_valid[i] && (m_tag[i] == addr[i]);
        check_output("slot_ok", 64'(bus.slot_ok), 64'(exp_ok));
        for (int i = 0; i < 4; i++)
            if (exp_ok[i]) check_output("slot_dout", 64'(bus.slot_dout[i*32 +: 32]), 64'(m_data[i]));
        check_output("sdram_req", 64'(bus.sdram_req), 64'(m_phase == 1));
        check_output("sdram_addr", 64'(bus.sdram_addr), 64'(m_addr));
        check_output("refresh_en", 64'(bus.refresh_en),
                     64'(downloading || (m_phase == 0 && model_pend() == 4'd0)));
    endtask

    // One clock: controller response, model step, then observe and compare
    task automatic apply_stimulus();
        bit ack_now, rdy_now;
        ack_now = 1'b0;
        rdy_now = 1'b0;
        if (!downloading) begin
            if (m_phase == 1 && !c_noack && c_ack_dly == 0) begin
                ack_now = 1'b1;
                rdy_now = (c_rdy_dly == 0);
            end else if (m_phase == 2 && c_rdy_dly == 0) begin
                rdy_now = 1'b1;
            end
        end
        bus.sdram_ack = ack_now;
        bus.data_rdy  = rdy_now;
        bus.data_read = rdy_now ? c_data : $urandom();
        if (rdy_now) last_rdy = cycles + 1;
        model_advance(ack_now, rdy_now);
        @(negedge clk);
        cycles++;
        if (bus.sdram_req === 1'b1 && !prev_req) obs.push_back(bus.sdram_addr);
        prev_req = (bus.sdram_req === 1'b1);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) apply_stimulus();
    endtask

    task automatic wait_obs(input int n, input int bound);
        for (int k = 0; k < bound && obs.size() < n; k++) apply_stimulus();
    endtask

    task automatic wait_req(input int bound);
        for (int k = 0; k < bound && bus.sdram_req !== 1'b1; k++) apply_stimulus();
    endtask

    initial begin
        int cnt;
        rst = 1'b1; vblank = 1'b0; downloading = 1'b0; cs = 4'd0;
        for (int i = 0; i < 4; i++) addr[i] = '0;
        bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0; bus.data_read = '0;
        m_phase = 0; m_age = 0; m_win = 0; m_rr = 3; m_addr = '0;
        c_ack_dly = 0; c_rdy_dly = 0; c_noack = 0; c_data = '0; o_data = '0;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_all();
        check_output("reset_dout", 64'(bus.slot_dout == '0), 64'(1));
        rst = 1'b0;
        run(2);

        // single fill on slot 0, slot_ok one cycle after data_rdy
        o_ack = 1; o_rdy = 2; o_data_en = 1; o_data = 32'hA5A5_1234;
        addr[0] = 22'h10000; cs = 4'b0001;
        for (int k = 0; k < 20 && bus.slot_ok[0] !== 1'b1; k++) apply_stimulus();
        check_output("t1_ok", 64'(bus.slot_ok[0]), 64'(1));
        check_output("t1_latency", 64'(cycles), 64'(last_rdy));
        check_output("t1_dout", 64'(bus.slot_dout[31:0]), 64'h A5A5_1234);
        o_ack = -1; o_rdy = -1; o_data_en = 0;
        run(3);

        // round-robin over 1,2,3, then priority slot 0 ahead of slot 1
        obs.delete();
        addr[1] = 22'h1100; addr[2] = 22'h2200; addr[3] = 22'h3300; cs = 4'b1110;
        wait_obs(3, 200);
        run(20);
        check_output("t2_rr0", 64'(obs[0]), 64'h1100);
        check_output("t2_rr1", 64'(obs[1]), 64'h2200);
        check_output("t2_rr2", 64'(obs[2]), 64'h3300);
        obs.delete();
        addr[0] = 22'h0400; addr[1] = 22'h1104; cs = 4'b0011;
        wait_obs(2, 200);
        run(20);
        check_output("t2_prio0", 64'(obs[0]), 64'h0400);
        check_output("t2_prio1", 64'(obs[1]), 64'h1104);

        // vblank gating of slots 2 and 3
        obs.delete();
        vblank = 1'b1; addr[2] = 22'h2208; addr[3] = 22'h3308; cs = 4'b1100;
        run(10);
        check_output("t3_gated", 64'(obs.size()), 64'(0));
        check_output("t3_refresh", 64'(bus.refresh_en), 64'(1));
        vblank = 1'b0;
        wait_obs(2, 200);
        run(20);
        check_output("t3_first", 64'(obs[0]), 64'h2208);
        check_output("t3_second", 64'(obs[1]), 64'h3308);

        // address change during a fill: old tag stored, new request follows
        obs.delete();
        o_ack = 1; o_rdy = 4;
        addr[1] = 22'h0200; cs = 4'b0010;
        wait_req(10);
        addr[1] = 22'h0204;
        wait_obs(2, 100);
        run(20);
        o_ack = -1; o_rdy = -1;
        check_output("t4_first", 64'(obs[0]), 64'h0200);
        check_output("t4_second", 64'(obs[1]), 64'h0204);
        check_output("t4_ok", 64'(bus.slot_ok[1]), 64'(1));

        // no ack: request held for TMO cycles, then reissued
        obs.delete();
        force_noack = 1;
        addr[0] = 22'h3000; cs = 4'b0001;
        wait_req(10);
        cnt = 0;
        while (bus.sdram_req === 1'b1 && cnt < 100) begin
            cnt++;
            apply_stimulus();
        end
        check_output("t5_timeout_len", 64'(cnt), 64'(TMO));
        force_noack = 0;
        wait_req(5);
        check_output("t5_reissue_cnt", 64'(obs.size()), 64'(2));
        check_output("t5_reissue_addr", 64'(obs[1]), 64'h3000);
        run(20);

        // download during WAIT flushes everything
        o_ack = 0; o_rdy = 10;
        addr[2] = 22'h2400; cs = 4'b0101;
        for (int k = 0; k < 20 && m_phase != 2; k++) apply_stimulus();
        downloading = 1'b1;
        apply_stimulus();
        check_output("t6_req", 64'(bus.sdram_req), 64'(0));
        check_output("t6_ok", 64'(bus.slot_ok), 64'(0));
        apply_stimulus();
        downloading = 1'b0;
        o_ack = -1; o_rdy = -1;
        obs.delete();
        wait_obs(1, 20);
        check_output("t6_refetch", 64'(obs[0]), 64'h3000);
        run(30);

        // randomized traffic
        random_noack = 1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = int'($urandom_range(0, 3));
                cs[s]   = 1'($urandom_range(0, 1));
                addr[s] = 22'(32'h10000 * (s + 1) + 4 * $urandom_range(0, 2));
            end
            if ($urandom_range(0, 24) == 0) vblank = ~vblank;
            downloading = ($urandom_range(0, 199) == 0);
            apply_stimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
